// File: rtl/stopwatch_timer_if.sv
// rtl/stopwatch_timer_if.sv - controller/display side bundle of the stopwatch timekeeping datapath
//
// master: controller/display side (drives enable_count, status, lap; observes time outputs)
// slave : stopwatch_timer (consumes controls, drives time_bcd, sec_tick, rollover, lap_bcd, lap_valid)
interface stopwatch_timer_if;
    logic        enable_count;
    logic [1:0]  status;
    logic        lap;
    logic [15:0] time_bcd;
    logic        sec_tick;
    logic        rollover;
    logic [15:0] lap_bcd;
    logic        lap_valid;

    modport master (
        output enable_count, status, lap,
        input  time_bcd, sec_tick, rollover, lap_bcd, lap_valid
    );

    modport slave (
        input  enable_count, status, lap,
        output time_bcd, sec_tick, rollover, lap_bcd, lap_valid
    );
endinterface

// File: rtl/stopwatch_timer.sv
// rtl/stopwatch_timer.sv - MM:SS BCD stopwatch timekeeping datapath with 1 s prescaler
//
// Optional feature macro: STOPWATCH_LAP_EN (lap capture register).
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   sw (slave)   enable_count/status/lap in; time_bcd, sec_tick, rollover,
//                lap_bcd, lap_valid out (all registered)
// Parameter:
//   TICK_DIV     clk cycles per one-second tick (>= 2)
module stopwatch_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    stopwatch_timer_if.slave  sw
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;

    logic [PW-1:0] prescaler;
    logic          clear;
    logic          second_done;
    logic [15:0]   time_next;
    logic          wrap;

    assign clear       = (sw.status == ST_IDLE);
    assign second_done = sw.enable_count && (prescaler == PRESC_MAX);

    // One BCD digit step. An out-of-range digit is treated as needing a step
    // even without carry-in, so corruption self-heals to 0 with a carry.
    function automatic logic [4:0] bcd_step(input logic [3:0] d,
                                            input logic [3:0] dmax,
                                            input logic       cin);
        logic go;
        go = cin || (d > dmax);
        if (!go)
            return {1'b0, d};
        else if (d >= dmax)
            return {1'b1, 4'd0};
        else
            return {1'b0, d + 4'd1};
    endfunction

    always_comb begin
        logic [4:0] s_ones, s_tens, m_ones, m_tens;
        s_ones    = bcd_step(sw.time_bcd[3:0],   4'd9, 1'b1);
        s_tens    = bcd_step(sw.time_bcd[7:4],   4'd5, s_ones[4]);
        m_ones    = bcd_step(sw.time_bcd[11:8],  4'd9, s_tens[4]);
        m_tens    = bcd_step(sw.time_bcd[15:12], 4'd9, m_ones[4]);
        time_next = {m_tens[3:0], m_ones[3:0], s_tens[3:0], s_ones[3:0]};
        wrap      = m_tens[4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            prescaler   <= '0;
            sw.time_bcd <= 16'h0000;
            sw.sec_tick <= 1'b0;
            sw.rollover <= 1'b0;
        end else begin
            sw.sec_tick <= 1'b0;
            sw.rollover <= 1'b0;
            if (sw.enable_count) begin
                if (second_done) begin
                    prescaler   <= '0;
                    sw.time_bcd <= time_next;
                    sw.sec_tick <= 1'b1;
                    sw.rollover <= wrap;
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Captures the time visible this cycle, i.e. the pre-increment value
    // when a lap coincides with a tick.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sw.lap_bcd   <= 16'h0000;
            sw.lap_valid <= 1'b0;
        end else if (sw.lap) begin
            sw.lap_bcd   <= sw.time_bcd;
            sw.lap_valid <= 1'b1;
        end
    end
`else
    logic unused_lap;
    assign unused_lap   = sw.lap;
    assign sw.lap_bcd   = 16'h0000;
    assign sw.lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb/tb_stopwatch_timer.sv - directed table-driven bench for stopwatch_timer (TICK_DIV = 4)
module tb_stopwatch_timer;

    logic clk;
    logic rst_n;

    stopwatch_timer_if sw_if ();

    stopwatch_timer #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [1:0]  st;
        logic [15:0] exp_time;
        logic        exp_tick;
        logic        exp_roll;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [1:0] st, input logic lp);
        rst_n           = r;
        sw_if.enable_count = en;
        sw_if.status    = st;
        sw_if.lap       = lp;
        @(posedge clk);
        #1;
    endtask

    // Runs one full enabled second; outputs afterwards reflect the tick cycle.
    task automatic run_sec();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 2'b01, 1'b0);
    endtask

    logic [15:0] exp_lap_bcd;
    logic        exp_lap_valid;

    initial begin
        rst_n = 1'b0;
        sw_if.enable_count = 1'b0;
        sw_if.status = 2'b00;
        sw_if.lap = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 2'b01, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 2'b01, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'b01, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'b01, 16'h0001, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'b01, 16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'b01, 16'h0001, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'b10, 16'h0001, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'b10, 16'h0001, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 2'b01, 16'h0001, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'b01, 16'h0002, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 2'b11, 16'h0002, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 2'b11, 16'h0002, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 2'b01, 16'h0000, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 2'b01, 16'h0000, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 2'b01, 16'h0000, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 2'b01, 16'h0001, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 2'b01, 16'h0000, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].st, 1'b0);
            check($sformatf("vec%0d time", i), sw_if.time_bcd, vecs[i].exp_time);
            check($sformatf("vec%0d tick", i), 16'(sw_if.sec_tick), 16'(vecs[i].exp_tick));
            check($sformatf("vec%0d roll", i), 16'(sw_if.rollover), 16'(vecs[i].exp_roll));
            check($sformatf("vec%0d lapv", i), 16'(sw_if.lap_valid), 16'h0000);
            check($sformatf("vec%0d lapb", i), sw_if.lap_bcd, 16'h0000);
        end

        // Carry chain from a reset state: 59 s then sec_tens -> min_ones carry
        for (int s = 0; s < 59; s++) run_sec();
        check("at_0059", sw_if.time_bcd, 16'h0059);
        run_sec();
        check("carry_0100", sw_if.time_bcd, 16'h0100);
        check("carry_0100 tick", 16'(sw_if.sec_tick), 16'h0001);
        check("carry_0100 roll", 16'(sw_if.rollover), 16'h0000);
        for (int s = 0; s < 539; s++) run_sec();
        check("at_0959", sw_if.time_bcd, 16'h0959);
        run_sec();
        check("carry_1000", sw_if.time_bcd, 16'h1000);

        // Wrap 99:59 -> 00:00
        for (int s = 0; s < 5399; s++) run_sec();
        check("at_9959", sw_if.time_bcd, 16'h9959);
        check("at_9959 roll", 16'(sw_if.rollover), 16'h0000);
        run_sec();
        check("wrap time", sw_if.time_bcd, 16'h0000);
        check("wrap roll", 16'(sw_if.rollover), 16'h0001);
        check("wrap tick", 16'(sw_if.sec_tick), 16'h0001);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        check("post_wrap roll", 16'(sw_if.rollover), 16'h0000);
        check("post_wrap tick", 16'(sw_if.sec_tick), 16'h0000);
        check("post_wrap time", sw_if.time_bcd, 16'h0000);

        // Clear priority at 0x0123, then first tick 4 enabled cycles later
        step(1'b1, 1'b0, 2'b00, 1'b0);
        for (int s = 0; s < 83; s++) run_sec();
        check("at_0123", sw_if.time_bcd, 16'h0123);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b1, 1'b1, 2'b00, 1'b1);
        check("clr time", sw_if.time_bcd, 16'h0000);
        check("clr lapv", 16'(sw_if.lap_valid), 16'h0000);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 2'b01, 1'b0);
        check("clr_presc no tick", 16'(sw_if.sec_tick), 16'h0000);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        check("clr_presc tick", 16'(sw_if.sec_tick), 16'h0001);
        check("clr_presc time", sw_if.time_bcd, 16'h0001);

        // Lap on a tick cycle at 0x0007
        for (int s = 0; s < 6; s++) run_sec();
        check("at_0007", sw_if.time_bcd, 16'h0007);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b1, 1'b1, 2'b01, 1'b1);
`ifdef STOPWATCH_LAP_EN
        exp_lap_bcd   = 16'h0007;
        exp_lap_valid = 1'b1;
`else
        exp_lap_bcd   = 16'h0000;
        exp_lap_valid = 1'b0;
`endif
        check("lap time", sw_if.time_bcd, 16'h0008);
        check("lap bcd", sw_if.lap_bcd, exp_lap_bcd);
        check("lap valid", 16'(sw_if.lap_valid), 16'(exp_lap_valid));
        // Held lap survives later seconds
        run_sec();
        check("lap hold bcd", sw_if.lap_bcd, exp_lap_bcd);
        // Lap in IDLE is ignored and clear drops valid
        step(1'b1, 1'b1, 2'b00, 1'b1);
        check("idle lap valid", 16'(sw_if.lap_valid), 16'h0000);
        check("idle lap bcd", sw_if.lap_bcd, 16'h0000);
        check("idle time", sw_if.time_bcd, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_timer.md
# stopwatch_timer

Timekeeping datapath for the stopwatch, driven by the run/pause/idle controller. It consumes the controller's `enable_count` and `status` outputs and divides `clk` down to a 1 s tick. It keeps an MM:SS time in BCD digits, 00:00 to 99:59, for the display driver. It also reports per-second and rollover events and, optionally, a captured lap time.

## Interface
- `TICK_DIV`, default 50_000_000: `clk` cycles per one-second tick; legal range ≥ 2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable_count`  in  1  high while controller is RUNNING; advances the prescaler.
- `status`  in  2  controller state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 unused.
- `lap`  in  1  one-cycle lap-capture request (functional only with the lap macro).
- `time_bcd`  out  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each, registered.
- `sec_tick`  out  1  one-cycle pulse, coincident with each `time_bcd` increment.
- `rollover`  out  1  one-cycle pulse when time wraps 99:59 → 00:00.
- `lap_bcd`  out  16  captured time, same packing as `time_bcd`.
- `lap_valid`  out  1  high once a lap has been captured since the last clear.

## Operation
- **Reset:** `time_bcd` = 0x0000, `sec_tick` = 0, `rollover` = 0, `lap_bcd` = 0x0000, `lap_valid` = 0, prescaler = 0.
- **Clear** (status == 00):
  - Synchronously zeroes the prescaler, `time_bcd`, `lap_bcd` and `lap_valid`; `sec_tick` and `rollover` are 0.
  - Clear has priority over `enable_count` and `lap` in the same cycle.
- **Count** (status != 00 and `enable_count` = 1):
  - Prescaler width is `$clog2(TICK_DIV)`; it counts 0 … `TICK_DIV`−1.
  - When the prescaler is at `TICK_DIV`−1, it wraps to 0 and the time increments by one second.
- **Hold** (status != 00 and `enable_count` = 0; covers PAUSED and 11):
  - Prescaler and time frozen.
  - A partial second is retained and resumes on the next enable.
- **BCD increment:**
  - `sec_ones` 0–9 carries into `sec_tens`.
  - `sec_tens` 0–5 carries into `min_ones`.
  - `min_ones` 0–9 carries into `min_tens`.
  - `min_tens` 0–9 wraps.
- **Wrap:** 99:59 + 1 s = 00:00 with `rollover` = 1; counting continues, with no saturation.
- No digit ever holds a value outside its range. An illegal digit can only be reached by corruption; on the next increment it is forced to 0 with a carry.

## Timing
- All outputs are registered; no combinational path from input to output.
- **Increment latency:**
  - `time_bcd` changes on the clock edge that ends the `TICK_DIV`-th enabled cycle after the last clear.
  - Example: `enable_count` high from cycle 0 gives the first change visible in cycle `TICK_DIV`.
- `sec_tick` and `rollover` are high in the same cycle as the updated `time_bcd`, for exactly one cycle.
- Clear takes effect on the next edge: `time_bcd` is 0x0000 one cycle after status = 00 is sampled.
- **Lap in the same cycle as an increment:** `lap_bcd` captures the pre-increment value, i.e. the `time_bcd` visible in that cycle.
- **Mid-operation reset:** `rst_n` low behaves like clear, and additionally forces pulses low, regardless of `status`.

## Configuration
- Macro `STOPWATCH_LAP_EN`.
- **Defined:**
  - `lap` = 1 with status != 00 loads `lap_bcd` ← `time_bcd` and sets `lap_valid` on the next edge.
  - Repeated laps overwrite the captured value.
  - `lap` is ignored in IDLE.
- **Undefined:** `lap` is ignored; `lap_bcd` is tied to 0x0000 and `lap_valid` to 0. The capture register is not built.
- Ports are identical in both builds.

## Test plan
All runs use `TICK_DIV` = 4.

1. **Reset:** `rst_n` low for 2 cycles → all outputs 0. Then `enable_count` = 1, status = 01 → `time_bcd` 0x0001 appears exactly 4 cycles later with `sec_tick` = 1 for one cycle.
2. **Carry chain:** run to 0x0059 → next tick gives 0x0100. Run to 0x0959 → next tick gives 0x1000.
3. **Wrap:** preload by running to 0x9959 → next tick gives 0x0000 with `rollover` = 1 and `sec_tick` = 1, both for one cycle.
4. **Pause:**
   - Run 2 enabled cycles, then `enable_count` = 0, status = 10 for 20 cycles → `time_bcd` unchanged.
   - Re-enable → increment after 2 more cycles (partial second kept).
5. **Clear priority:** status = 00 with `enable_count` = 1 at `time_bcd` 0x0123 → next cycle `time_bcd` is 0x0000 and the prescaler is 0; the first tick comes 4 enabled cycles after status leaves 00.
6. **Lap** (`STOPWATCH_LAP_EN` defined):
   - `lap` pulse at 0x0007 on a tick cycle → `lap_bcd` = 0x0007, `lap_valid` = 1, `time_bcd` = 0x0008.
   - Then status = 00 → `lap_valid` = 0.
   - With the macro undefined → `lap_bcd` stays 0x0000.
